// File: rtl/raddr_gen_2d_pkg.sv
// rtl/raddr_gen_2d_pkg.sv - shared constants for the 2D read-address generator
package raddr_gen_2d_pkg;

   // One-hot walker states
   localparam logic [2:0] ST_IDLE  = 3'b001;
   localparam logic [2:0] ST_SEND  = 3'b010;
   localparam logic [2:0] ST_DRAIN = 3'b100;

   // Defaults for the data path geometry
   localparam int BEAT_BYTES_DEF = 128;
   localparam int AXI_LEN_W      = 8;

   // Credit counter width; covers limits up to 15 outstanding bursts
   localparam int CREDIT_W = 4;

endpackage

// File: rtl/raddr_credit_cnt.sv
// rtl/raddr_credit_cnt.sv - outstanding-burst up/down counter with limit flag
module raddr_credit_cnt
   import raddr_gen_2d_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output logic credit_ok_next,
   output logic empty_next
);

   localparam logic [CREDIT_W-1:0] LIMIT   = CREDIT_W'(MAX_OUTSTANDING);
   localparam logic [CREDIT_W-1:0] CNT_TOP = '1;

   logic [CREDIT_W-1:0] cnt_q;
   logic [CREDIT_W-1:0] cnt_d;

   // Next count: simultaneous inc/dec cancel, never wrap past either end
   always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec && (cnt_q != CNT_TOP)) begin
         cnt_d = cnt_q + CREDIT_W'(1);
      end else if (dec && !inc && (cnt_q != '0)) begin
         cnt_d = cnt_q - CREDIT_W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Flags look at the post-update count so the walker reacts this cycle
   assign credit_ok_next = (cnt_d < LIMIT);
   assign empty_next     = (cnt_d == '0);

endmodule

// File: rtl/raddr_gen_2d.sv
// rtl/raddr_gen_2d.sv - AXI read-address generator walking a 2D burst rectangle
module raddr_gen_2d
   import raddr_gen_2d_pkg::*;
#(
   parameter int ADDR_W          = 64,
   parameter int LEN_W           = AXI_LEN_W,
   parameter int DIM_W           = 10,
   parameter int BEAT_BYTES      = BEAT_BYTES_DEF,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_pulse,
   input  logic [ADDR_W-1:0] source_address,
   input  logic [ADDR_W-1:0] row_stride,
   input  logic [DIM_W-1:0]  col_num,
   input  logic [DIM_W-1:0]  row_num,
   input  logic [LEN_W-1:0]  burst_len,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic [LEN_W-1:0]  m_axi_arlen,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   input  logic              rd_burst_done,
   output logic              busy,
   output logic              done
);

   localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

   logic [2:0]        state_q,    state_d;
   logic [ADDR_W-1:0] araddr_q,   araddr_d;
   logic [LEN_W-1:0]  arlen_q,    arlen_d;
   logic              arvalid_q,  arvalid_d;
   logic              busy_q,     busy_d;
   logic              done_q,     done_d;
   logic [DIM_W-1:0]  col_q,      col_d;
   logic [DIM_W-1:0]  row_q,      row_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [ADDR_W-1:0] stride_q,   stride_d;
   logic [DIM_W-1:0]  col_num_q,  col_num_d;
   logic [DIM_W-1:0]  row_num_q,  row_num_d;

   logic              hs;
   logic              credit_ok_next;
   logic              empty_next;
   logic [ADDR_W-1:0] burst_bytes;
   logic [ADDR_W-1:0] next_row_base;

   assign hs            = arvalid_q && m_axi_arready;
   assign burst_bytes   = (ADDR_W'(arlen_q) + ADDR_W'(1)) << BEAT_SHIFT;
   assign next_row_base = row_base_q + stride_q;

   raddr_credit_cnt #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_credit (
      .clk            (clk),
      .rst            (rst),
      .inc            (hs),
      .dec            (rd_burst_done),
      .credit_ok_next (credit_ok_next),
      .empty_next     (empty_next)
   );

   // Walker: latch the job, step column/row on each handshake, drain credits
   always_comb begin
      state_d    = state_q;
      araddr_d   = araddr_q;
      arlen_d    = arlen_q;
      arvalid_d  = arvalid_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      col_d      = col_q;
      row_d      = row_q;
      row_base_d = row_base_q;
      stride_d   = stride_q;
      col_num_d  = col_num_q;
      row_num_d  = row_num_q;
      case (state_q)
         ST_IDLE: begin
            if (start_pulse) begin
               araddr_d   = source_address;
               row_base_d = source_address;
               stride_d   = row_stride;
               col_num_d  = col_num;
               row_num_d  = row_num;
               arlen_d    = burst_len;
               col_d      = '0;
               row_d      = '0;
               busy_d     = 1'b1;
               arvalid_d  = credit_ok_next;
               state_d    = ST_SEND;
            end
         end
         ST_SEND: begin
            if (hs) begin
               if (col_q != col_num_q) begin
                  araddr_d  = araddr_q + burst_bytes;
                  col_d     = col_q + DIM_W'(1);
                  arvalid_d = credit_ok_next;
               end else if (row_q != row_num_q) begin
                  row_base_d = next_row_base;
                  araddr_d   = next_row_base;
                  col_d      = '0;
                  row_d      = row_q + DIM_W'(1);
                  arvalid_d  = credit_ok_next;
               end else begin
                  arvalid_d = 1'b0;
                  state_d   = ST_DRAIN;
               end
            end else if (!arvalid_q) begin
               // Credit is only consulted while arvalid is low, so a raised
               // arvalid is never withdrawn before its handshake
               arvalid_d = credit_ok_next;
            end
         end
         ST_DRAIN: begin
            if (empty_next) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            arvalid_d = 1'b0;
            busy_d    = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset abandons any walk in progress
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         araddr_q   <= '0;
         arlen_q    <= '0;
         arvalid_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
         row_base_q <= '0;
         stride_q   <= '0;
         col_num_q  <= '0;
         row_num_q  <= '0;
      end else begin
         state_q    <= state_d;
         araddr_q   <= araddr_d;
         arlen_q    <= arlen_d;
         arvalid_q  <= arvalid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         col_q      <= col_d;
         row_q      <= row_d;
         row_base_q <= row_base_d;
         stride_q   <= stride_d;
         col_num_q  <= col_num_d;
         row_num_q  <= row_num_d;
      end
   end

   assign m_axi_araddr  = araddr_q;
   assign m_axi_arlen   = arlen_q;
   assign m_axi_arvalid = arvalid_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: doc/raddr_gen_2d.md
Name: raddr_gen_2d

Overview:
- Parametrised AXI read-address generator; walks a 2D rectangle of fixed-length bursts (cols × rows) from a base address with programmable row stride.
- Successor of the single-mode fixed-burst read-address channel: adds configurable burst length, row stride, back-to-back issue and outstanding-burst credit limiting, plus busy/done status.
- Sits between the control/register block and the AXI master read-address channel; the read-data channel feeds completions back via rd_burst_done.

Parameters:
- ADDR_W, 64, AXI address width
- LEN_W, 8, arlen width
- DIM_W, 10, width of column/row count fields
- BEAT_BYTES, 128, bytes per data beat (power of two)
- MAX_OUTSTANDING, 4, max issued-but-uncompleted bursts (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start_pulse  in  1  one-cycle start; sampled only in IDLE
- source_address  in  ADDR_W  rectangle base byte address
- row_stride  in  ADDR_W  byte offset between row starts
- col_num  in  DIM_W  bursts per row minus 1
- row_num  in  DIM_W  rows minus 1
- burst_len  in  LEN_W  beats per burst minus 1 (driven on arlen)
- m_axi_araddr  out  ADDR_W  burst address
- m_axi_arlen  out  LEN_W  burst length
- m_axi_arvalid  out  1  address valid
- m_axi_arready  in  1  address ready
- rd_burst_done  in  1  one-cycle pulse per completed read burst (rvalid & rready & rlast)
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse when all bursts issued and completed

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: state IDLE, araddr 0, arlen 0, arvalid 0, busy 0, done 0, counters 0, outstanding 0. Reset mid-transfer abandons the walk immediately; arvalid drops asynchronously.
- States: IDLE, SEND, DRAIN (one-hot).
- IDLE: on start_pulse, latch source_address, row_stride, col_num, row_num, burst_len into shadow registers; araddr <= source_address, row_base <= source_address, col = row = 0; next state SEND. start_pulse outside IDLE is ignored.
- SEND: arvalid = (outstanding < MAX_OUTSTANDING). araddr/arlen held stable while arvalid && !arready. A withdrawn arvalid only occurs before assertion, never after (AXI rule: once high, held until handshake; the credit check is made only while arvalid is low).
- Handshake (arvalid & arready):
  - col < col_num: araddr += (burst_len+1)*BEAT_BYTES, col++.
  - col == col_num, row < row_num: row_base += row_stride, araddr <= row_base + row_stride, col = 0, row++.
  - last burst (col==col_num && row==row_num): arvalid low next cycle; next state DRAIN.
  - No handshake: stay in SEND. Back-to-back issue allowed: arvalid may stay high on the cycle after a handshake, giving one burst per cycle.
- Address arithmetic is modulo 2^ADDR_W. 4KB-crossing avoidance and alignment are the programmer's responsibility; the block does not split bursts.
- Outstanding counter: +1 on handshake, -1 on rd_burst_done; both in the same cycle gives no change; rd_burst_done at 0 is ignored (no underflow).
- DRAIN: wait for outstanding == 0 (including a decrement in the current cycle), then done = 1 for one cycle and go to IDLE. busy falls in the same cycle as done.
- Latency: start_pulse in cycle N gives arvalid high in N+1 (credit permitting).
- Total bursts per job = (col_num+1)*(row_num+1). col_num = row_num = 0 gives a single burst.

Decomposition:
- Shared package: state encodings (IDLE/SEND/DRAIN), BEAT_BYTES default, AXI length width constant.
- One natural sub-module: raddr_credit_cnt, the outstanding up/down counter with saturation/underflow guard and a less-than-limit flag.

Test Plan:
- Single burst: base 0x1000, col_num 0, row_num 0, len 3, arready tied 1 -> one AR at 0x1000, arlen 3; done 1 cycle after rd_burst_done; busy 1→0.
- 2D walk: base 0x0, BEAT_BYTES 128, len 1, col_num 2, row_num 1, stride 0x1000 -> addresses 0x000, 0x100, 0x200, 0x1000, 0x1100, 0x1200 in order, back-to-back with arready=1.
- Credit limit: MAX_OUTSTANDING 4, 8 bursts, no rd_burst_done -> exactly 4 handshakes, then arvalid low; one rd_burst_done -> exactly one more AR issued.
- Backpressure: arready low for 5 cycles mid-job -> araddr/arlen stable and arvalid held high throughout; sequence unchanged.
- Simultaneous events: handshake and rd_burst_done in same cycle -> outstanding unchanged; start_pulse while busy -> ignored, shadow config unchanged.
- Reset mid-job: assert rst during SEND -> arvalid, busy 0 immediately; after release, new start at 0x2000 issues from 0x2000 with outstanding 0.
